// File: rtl/tb_cmd_dispatcher.sv
// Scenario command dispatcher: queues keyword commands, issues each to one target with a
// one-cycle args strobe, then waits for that target's done under a watchdog.
module tb_cmd_dispatcher #(
  parameter int unsigned ARGS_NB     = 5,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned WDOG_CYCLES = 1000000,
  parameter int unsigned ARG_CHARS   = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_cmd_valid,
  output logic                                 o_cmd_ready,
  input  logic [ARGS_NB-1:0][8*ARG_CHARS-1:0]  i_cmd_args,
  output logic [3:0]                           o_sel,
  output logic                                 o_args_valid,
  output logic [ARGS_NB-1:0][8*ARG_CHARS-1:0]  o_args,
  input  logic [3:0]                           i_done,
  output logic                                 o_busy,
  output logic                                 o_cmd_error,
  output logic                                 o_timeout,
  output logic                                 o_finished,
  output logic [15:0]                          o_cmd_cnt,
  output logic [15:0]                          o_err_cnt
);

  localparam int unsigned ArgW  = 8 * ARG_CHARS;
  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);

  // Keywords are right-justified ASCII, zero padded, matching string-literal packing.
  localparam logic [ArgW-1:0] KwWait = ArgW'("WAIT");
  localparam logic [ArgW-1:0] KwSet  = ArgW'("SET");
  localparam logic [ArgW-1:0] KwWtr  = ArgW'("WTR");
  localparam logic [ArgW-1:0] KwChk  = ArgW'("CHK");
  localparam logic [ArgW-1:0] KwEnd  = ArgW'("END");

  typedef logic [ARGS_NB-1:0][ArgW-1:0] args_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitDone,
    StHalt
  } state_e;

  // FIFO storage and pointers.
  args_t            r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  args_t            w_head;

  // Control state.
  state_e           r_state;
  state_e           w_state_nxt;
  logic [3:0]       r_sel;
  logic [3:0]       w_sel_nxt;
  args_t            r_args;
  args_t            w_args_nxt;
  logic             r_cmd_error;
  logic             w_cmd_error_nxt;
  logic             r_timeout;
  logic             w_timeout_nxt;
  logic             r_finished;
  logic             w_finished_nxt;
  logic [15:0]      r_cmd_cnt;
  logic [15:0]      w_cmd_cnt_nxt;
  logic [15:0]      r_err_cnt;
  logic [15:0]      w_err_cnt_nxt;
  logic             w_err_inc;
  logic [WdogW-1:0] r_wdog;
  logic [WdogW-1:0] w_wdog_nxt;
  logic [3:0]       w_kw_sel;
  logic             w_kw_end;

  assign w_full  = (r_count == CntW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = i_cmd_valid & ~w_full;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_cmd_args;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Keyword decode of the FIFO head.
  always_comb begin
    w_kw_sel = 4'b0000;
    w_kw_end = 1'b0;
    if (w_head[0] == KwWait)     w_kw_sel = 4'b0001;
    else if (w_head[0] == KwSet) w_kw_sel = 4'b0010;
    else if (w_head[0] == KwWtr) w_kw_sel = 4'b0100;
    else if (w_head[0] == KwChk) w_kw_sel = 4'b1000;
    else if (w_head[0] == KwEnd) w_kw_end = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_sel       <= 4'b0000;
      r_args      <= '0;
      r_cmd_error <= 1'b0;
      r_timeout   <= 1'b0;
      r_finished  <= 1'b0;
      r_cmd_cnt   <= 16'd0;
      r_err_cnt   <= 16'd0;
      r_wdog      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_args      <= w_args_nxt;
      r_cmd_error <= w_cmd_error_nxt;
      r_timeout   <= w_timeout_nxt;
      r_finished  <= w_finished_nxt;
      r_cmd_cnt   <= w_cmd_cnt_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
      r_wdog      <= w_wdog_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pop           = 1'b0;
    w_sel_nxt       = r_sel;
    w_args_nxt      = r_args;
    w_cmd_error_nxt = 1'b0;
    w_timeout_nxt   = r_timeout;
    w_finished_nxt  = r_finished;
    w_cmd_cnt_nxt   = r_cmd_cnt;
    w_err_inc       = 1'b0;
    w_wdog_nxt      = r_wdog;

    unique case (r_state)
      StIdle: begin
        if (!w_empty && !r_finished) begin
          w_pop = 1'b1;
          if (w_kw_sel != 4'b0000) begin
            w_sel_nxt   = w_kw_sel;
            w_args_nxt  = w_head;
            w_state_nxt = StIssue;
          end else if (w_kw_end) begin
            w_finished_nxt = 1'b1;
            w_state_nxt    = StHalt;
          end else begin
            w_cmd_error_nxt = 1'b1;
            w_err_inc       = 1'b1;
          end
        end
      end
      StIssue: begin
        w_wdog_nxt  = '0;
        w_state_nxt = StWaitDone;
      end
      StWaitDone: begin
        // Done is checked first so it wins over a coincident watchdog expiry.
        if ((i_done & r_sel) != 4'b0000) begin
          w_sel_nxt     = 4'b0000;
          w_cmd_cnt_nxt = r_cmd_cnt + 16'd1;
          w_state_nxt   = StIdle;
        end else if (r_wdog == WdogW'(WDOG_CYCLES - 1)) begin
          w_sel_nxt     = 4'b0000;
          w_timeout_nxt = 1'b1;
          w_err_inc     = 1'b1;
          w_state_nxt   = StIdle;
        end else begin
          w_wdog_nxt = r_wdog + 1'b1;
        end
      end
      StHalt: begin
        w_sel_nxt = 4'b0000;
      end
      default: begin
        w_sel_nxt   = 4'b0000;
        w_state_nxt = StIdle;
      end
    endcase

    w_err_cnt_nxt = r_err_cnt;
    if (w_err_inc && (r_err_cnt != 16'hFFFF)) begin
      w_err_cnt_nxt = r_err_cnt + 16'd1;
    end
  end

  assign o_cmd_ready  = ~w_full;
  assign o_sel        = r_sel;
  assign o_args       = r_args;
  assign o_args_valid = (r_state == StIssue);
  assign o_busy       = ((r_state != StIdle) && (r_state != StHalt)) || !w_empty;
  assign o_cmd_error  = r_cmd_error;
  assign o_timeout    = r_timeout;
  assign o_finished   = r_finished;
  assign o_cmd_cnt    = r_cmd_cnt;
  assign o_err_cnt    = r_err_cnt;

  a_valid_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    o_args_valid |-> $onehot(o_sel));

endmodule

// File: tb/tb_tb_cmd_dispatcher.sv
// Scoreboard bench for tb_cmd_dispatcher: stimulus queues expected issues, a monitor pops
// and compares on every args strobe, a target model answers done with programmable delay.
module tb_tb_cmd_dispatcher;

  localparam int unsigned ArgsNb = 5;
  localparam int unsigned ArgW   = 64;

  typedef struct {
    logic [3:0]                   sel;
    logic [ArgsNb-1:0][ArgW-1:0]  args;
  } exp_t;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          i_cmd_valid;
  logic                          o_cmd_ready;
  logic [ArgsNb-1:0][ArgW-1:0]   i_cmd_args;
  logic [3:0]                    o_sel;
  logic                          o_args_valid;
  logic [ArgsNb-1:0][ArgW-1:0]   o_args;
  logic [3:0]                    i_done;
  logic                          o_busy;
  logic                          o_cmd_error;
  logic                          o_timeout;
  logic                          o_finished;
  logic [15:0]                   o_cmd_cnt;
  logic [15:0]                   o_err_cnt;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  int   n_strobes = 0;
  int   err_pulses = 0;
  int   cur_len = 0;
  int   last_sel_len = 0;
  logic [3:0] prev_sel = 4'b0000;

  // Target model controls.
  int   resp_delay = 1;
  logic block_done = 1'b0;
  logic noise = 1'b0;

  tb_cmd_dispatcher #(
    .ARGS_NB     (ArgsNb),
    .FIFO_DEPTH  (8),
    .WDOG_CYCLES (16),
    .ARG_CHARS   (8)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_args   (i_cmd_args),
    .o_sel        (o_sel),
    .o_args_valid (o_args_valid),
    .o_args       (o_args),
    .i_done       (i_done),
    .o_busy       (o_busy),
    .o_cmd_error  (o_cmd_error),
    .o_timeout    (o_timeout),
    .o_finished   (o_finished),
    .o_cmd_cnt    (o_cmd_cnt),
    .o_err_cnt    (o_err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [ArgW-1:0] s2a(input string s);
    logic [ArgW-1:0] v = '0;
    for (int i = 0; i < s.len(); i++) v = {v[ArgW-9:0], s[i]};
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Called at a falling edge; returns one falling edge later.
  task automatic push(input string a0, input string a1, input string a2,
                      input logic [3:0] exp_sel, output logic accepted);
    exp_t e;
    e.sel  = exp_sel;
    e.args = '0;
    e.args[0] = s2a(a0);
    e.args[1] = s2a(a1);
    e.args[2] = s2a(a2);
    i_cmd_args  = e.args;
    i_cmd_valid = 1'b1;
    accepted    = o_cmd_ready;
    if (accepted && exp_sel != 4'b0000) sb.push_back(e);
    @(negedge clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (o_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (o_busy) check("idle_bound", 64'(o_busy), 64'd0);
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: scoreboard compare on each strobe, plus sel-length and error-pulse tracking.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_args_valid) begin
        n_strobes++;
        check("issue_gap_prev_sel", 64'(prev_sel), 64'd0);
        if (sb.size() == 0) begin
          check("sb_unexpected_issue_sel", 64'(o_sel), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_sel", 64'(o_sel), 64'(e.sel));
          for (int i = 0; i < ArgsNb; i++) check("sb_args", o_args[i], e.args[i]);
        end
      end
      if (o_cmd_error) err_pulses++;
      if (o_sel != 4'b0000) begin
        cur_len++;
      end else if (cur_len != 0) begin
        last_sel_len = cur_len;
        cur_len = 0;
      end
    end else begin
      cur_len = 0;
    end
    prev_sel = o_sel;
  end

  // Target model: done pulse resp_delay cycles after the strobe (never if negative).
  initial begin : target_model
    logic [3:0] pend_sel;
    int         pend_cnt;
    logic       pending;
    pending  = 1'b0;
    pend_sel = 4'b0000;
    pend_cnt = 0;
    i_done   = 4'b0000;
    forever begin
      @(negedge clk);
      i_done = 4'b0000;
      if (o_args_valid) begin
        pending  = 1'b1;
        pend_sel = o_sel;
        pend_cnt = 0;
      end else if (o_sel == 4'b0000) begin
        pending = 1'b0;
      end else if (pending) begin
        pend_cnt++;
        if (noise) i_done = ~pend_sel;
        if (!block_done && resp_delay >= 0 && pend_cnt >= resp_delay) begin
          i_done  = pend_sel;
          pending = 1'b0;
        end
      end
    end
  end

  initial begin : global_bound
    #200000;
    $display("FAIL global_timeout: got running, required finished");
    $fatal(1, "bench time limit");
  end

  initial begin : main
    logic acc;
    int   s0;
    rst_n       = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd_args  = '0;
    @(negedge clk);
    do_reset(2);
    @(negedge clk);

    // Reset state.
    check("rst_sel", 64'(o_sel), 64'd0);
    check("rst_args_valid", 64'(o_args_valid), 64'd0);
    check("rst_cmd_error", 64'(o_cmd_error), 64'd0);
    check("rst_timeout", 64'(o_timeout), 64'd0);
    check("rst_finished", 64'(o_finished), 64'd0);
    check("rst_cmd_cnt", 64'(o_cmd_cnt), 64'd0);
    check("rst_err_cnt", 64'(o_err_cnt), 64'd0);
    check("rst_args0", o_args[0], 64'd0);
    check("rst_ready", 64'(o_cmd_ready), 64'd1);
    check("rst_busy", 64'(o_busy), 64'd0);

    // WAIT with done 10 cycles after the strobe: sel high on strobe + 10 wait cycles.
    resp_delay = 10;
    push("WAIT", "10", "ns", 4'b0001, acc);
    wait_idle(100);
    check("t1_cmd_cnt", 64'(o_cmd_cnt), 64'd1);
    check("t1_busy", 64'(o_busy), 64'd0);
    check("t1_sel_len", 64'(last_sel_len), 64'd11);
    check("t1_strobes", 64'(n_strobes), 64'd1);

    // Fill the FIFO while the first command is blocked; 9th push is refused.
    resp_delay = 2;
    block_done = 1'b1;
    push("WAIT", "5", "ns", 4'b0001, acc);
    push("SET", "A", "1", 4'b0010, acc);
    push("WTR", "B", "", 4'b0100, acc);
    push("CHK", "C", "0", 4'b1000, acc);
    push("WAIT", "2", "ns", 4'b0001, acc);
    push("SET", "D", "0", 4'b0010, acc);
    push("WTR", "E", "", 4'b0100, acc);
    push("CHK", "F", "1", 4'b1000, acc);
    push("WAIT", "3", "us", 4'b0001, acc);
    check("t2_8th_accepted", 64'(acc), 64'd1);
    push("SET", "X", "9", 4'b0010, acc);
    check("t2_full_ready", 64'(acc), 64'd0);
    block_done = 1'b0;
    wait_idle(400);
    check("t2_cmd_cnt", 64'(o_cmd_cnt), 64'd10);
    check("t2_strobes", 64'(n_strobes), 64'd10);
    check("t2_sb_empty", 64'(sb.size()), 64'd0);
    check("t2_timeout", 64'(o_timeout), 64'd0);

    // Unknown keyword then a SET.
    resp_delay = 1;
    push("FOO", "", "", 4'b0000, acc);
    push("SET", "A", "1", 4'b0010, acc);
    wait_idle(100);
    check("t3_err_pulses", 64'(err_pulses), 64'd1);
    check("t3_err_cnt", 64'(o_err_cnt), 64'd1);
    check("t3_cmd_cnt", 64'(o_cmd_cnt), 64'd11);

    // Watchdog: target silent, unselected done bits toggling must be ignored.
    resp_delay = -1;
    noise = 1'b1;
    push("WAIT", "1", "us", 4'b0001, acc);
    wait_idle(100);
    noise = 1'b0;
    check("t4_timeout", 64'(o_timeout), 64'd1);
    check("t4_err_cnt", 64'(o_err_cnt), 64'd2);
    check("t4_cmd_cnt", 64'(o_cmd_cnt), 64'd11);
    check("t4_sel_len", 64'(last_sel_len), 64'd17);
    resp_delay = 1;
    push("CHK", "Z", "", 4'b1000, acc);
    wait_idle(100);
    check("t4_next_cmd_cnt", 64'(o_cmd_cnt), 64'd12);
    check("t4_timeout_sticky", 64'(o_timeout), 64'd1);

    // END halts; the trailing WAIT stays queued and is never issued.
    s0 = n_strobes;
    push("CHK", "", "", 4'b1000, acc);
    push("END", "", "", 4'b0000, acc);
    push("WAIT", "1", "ns", 4'b0000, acc);
    repeat (20) @(negedge clk);
    check("t5_finished", 64'(o_finished), 64'd1);
    check("t5_busy", 64'(o_busy), 64'd1);
    check("t5_cmd_cnt", 64'(o_cmd_cnt), 64'd13);
    check("t5_strobes", 64'(n_strobes - s0), 64'd1);
    check("t5_sel", 64'(o_sel), 64'd0);
    for (int i = 0; i < 7; i++) push("SET", "", "", 4'b0000, acc);
    check("t5_7th_fill_accepted", 64'(acc), 64'd1);
    push("SET", "", "", 4'b0000, acc);
    check("t5_full_with_one_retained", 64'(acc), 64'd0);
    check("t5_sb_empty", 64'(sb.size()), 64'd0);

    // One-cycle reset while waiting for done with three commands queued.
    do_reset(2);
    @(negedge clk);
    resp_delay = -1;
    push("WAIT", "9", "ns", 4'b0001, acc);
    push("SET", "Q", "1", 4'b0000, acc);
    push("WTR", "R", "", 4'b0000, acc);
    push("CHK", "S", "", 4'b0000, acc);
    do_reset(1);
    check("t6_sel", 64'(o_sel), 64'd0);
    check("t6_busy", 64'(o_busy), 64'd0);
    check("t6_ready", 64'(o_cmd_ready), 64'd1);
    check("t6_cmd_cnt", 64'(o_cmd_cnt), 64'd0);
    check("t6_err_cnt", 64'(o_err_cnt), 64'd0);
    check("t6_timeout", 64'(o_timeout), 64'd0);
    check("t6_finished", 64'(o_finished), 64'd0);
    check("t6_args0", o_args[0], 64'd0);
    s0 = n_strobes;
    repeat (5) @(negedge clk);
    check("t6_no_issue", 64'(n_strobes - s0), 64'd0);
    resp_delay = 1;
    push("SET", "A", "1", 4'b0010, acc);
    wait_idle(100);
    check("t6_new_cmd_cnt", 64'(o_cmd_cnt), 64'd1);
    check("t6_sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tb_cmd_dispatcher.md
Name: tb_cmd_dispatcher

Overview:
Testbench-side command initiator that drives the scenario command modules (wait_duration, set, wait-trigger, check). It buffers string commands in a small FIFO, decodes the keyword in args[0], and selects exactly one target with a one-hot sel. It presents the args with a one-cycle valid pulse, then waits for that target's done. A watchdog flags hung targets, and the block keeps running counters and sticky status for the scenario runner.

Parameters:
ARGS_NB, 5, number of string arguments per command (args[0] = keyword)
FIFO_DEPTH, 8, command FIFO depth in entries, power of 2, >= 2
WDOG_CYCLES, 1000000, max clk cycles spent in WAIT_DONE before abort

Ports:
clk  input  1  clock
rst_n  input  1  synchronous reset, active-low
i_cmd_valid  input  1  command push request
o_cmd_ready  output  1  FIFO not full; push accepted when i_cmd_valid & o_cmd_ready
i_cmd_args  input  string[ARGS_NB]  command to push
o_sel  output  4  one-hot target select: [0] WAIT, [1] SET, [2] WTR, [3] CHK
o_args_valid  output  1  one-cycle args strobe to selected target
o_args  output  string[ARGS_NB]  current command args, held while o_sel != 0
i_done  input  4  per-target done (level or pulse), index as o_sel
o_busy  output  1  FSM not in IDLE, or FIFO not empty
o_cmd_error  output  1  one-cycle pulse: unknown keyword popped
o_timeout  output  1  sticky: a watchdog abort occurred
o_finished  output  1  sticky: "END" popped
o_cmd_cnt  output  16  commands completed by done, wraps at 16'hFFFF->0
o_err_cnt  output  16  unknown-keyword plus timeout events, saturating at 16'hFFFF

Behaviour:
- Reset (rst_n=0 at posedge):
  - FSM to IDLE; FIFO emptied.
  - o_sel=0, o_args_valid=0, o_cmd_error=0, o_timeout=0, o_finished=0, cnts=0.
  - o_args all "". o_cmd_ready=1 from the first cycle after reset.
  - Reset mid-command drops sel immediately; no done is awaited.
- FIFO:
  - Push and pop in the same cycle are allowed.
  - When full, o_cmd_ready=0 and the push is ignored.
  - Pointers wrap modulo FIFO_DEPTH. Ordering is strict FIFO.
- FSM states: IDLE, ISSUE, WAIT_DONE, HALT.
- IDLE:
  - If FIFO is non-empty and o_finished=0: pop the head into the cmd register and decode args[0].
  - "WAIT"/"SET"/"WTR"/"CHK" -> load o_args and the one-hot o_sel, go to ISSUE.
  - "END" -> set o_finished, go to HALT.
  - Any other keyword -> pulse o_cmd_error, increment o_err_cnt, stay in IDLE. The next pop may occur on the following cycle.
- ISSUE (exactly 1 cycle): o_args_valid=1 and o_sel held; go to WAIT_DONE. The watchdog counter is cleared.
- WAIT_DONE:
  - o_sel and o_args are held; o_args_valid=0.
  - i_done[k] is sampled only for the selected k; other i_done bits are ignored.
  - On i_done[k]=1: clear o_sel, increment o_cmd_cnt, go to IDLE.
  - Otherwise the watchdog increments. When it reaches WDOG_CYCLES-1: set o_timeout, increment o_err_cnt, clear o_sel, go to IDLE. The command is not counted.
  - If done and the watchdog limit coincide on the same cycle, done wins.
- HALT: terminal until reset. o_sel=0, no pops; FIFO contents are retained and pushes are still accepted.
- Latency: push at edge t into empty FIFO in IDLE:
  - pop at edge t+1;
  - o_sel and o_args_valid high in cycle t+1..t+2;
  - WAIT_DONE from t+2.
  - Minimum one cycle with o_sel=0 between consecutive commands, because IDLE is always re-entered.
- o_args_valid never asserts without exactly one o_sel bit high.
- o_busy = (state != IDLE && state != HALT) || FIFO non-empty.

Test Plan:
- Push {"WAIT","10","ns"} with a target model asserting i_done[0] 10 cycles after o_args_valid -> o_sel=4'b0001 held for 11 cycles after the strobe, single o_args_valid pulse, o_cmd_cnt=1, o_busy=0 afterwards.
- Push 8 commands back-to-back while FSM is blocked in WAIT_DONE -> 9th push sees o_cmd_ready=0. Release done -> commands issued in push order with the SET/WTR/CHK/WAIT one-hot pattern, gap of >=1 idle sel cycle each; o_cmd_cnt=8.
- Push {"FOO"} then {"SET","A","1"} -> o_cmd_error single pulse, o_err_cnt=1, SET issued with o_sel=4'b0010 on the next pop.
- WDOG_CYCLES=16, target never responds -> o_sel drops after 16 WAIT_DONE cycles, o_timeout=1 sticky, o_err_cnt=1, o_cmd_cnt=0, next command proceeds.
- Push {"CHK"},{"END"},{"WAIT","1","ns"} -> CHK completes, o_finished=1, WAIT never issued, FIFO holds 1 entry, o_busy=1.
- Assert rst_n=0 for 1 cycle during WAIT_DONE with 3 queued -> o_sel=0 next cycle, FIFO empty, all counters 0, no issue until a new push.
